cla_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor.
- Splits a WIDTH-bit operation into 4-bit lookahead groups, one group per pipeline stage; the group carry is registered between stages.
- Valid/ready handshake on input and output; full throughput of one operation per cycle.
- Serves as the wide arithmetic primitive for datapaths that need more width than a single-cycle 4-bit lookahead slice can close timing on.

---
 rtl/arith_pkg.sv | 11 +
 rtl/cla_group4.sv | 30 +++
 rtl/cla_pipe_addsub.sv | 116 +++++++++++
 tb/tb_cla_pipe_addsub.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared constants and helpers for the carry-lookahead arithmetic blocks.
package arith_pkg;

  localparam int GROUP_W = 4;

  // Number of 4-bit lookahead groups (and pipeline stages) for a given width.
  function automatic int group_count(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead slice; every carry is a flat sum of products.
// Zero latency, no handshake.
module cla_group4
  import arith_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               c0,
  output logic [GROUP_W-1:0] s,
  output logic               c3,
  output logic               c4
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic               c1;
  logic               c2;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);

  assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined lookahead add/sub, one 4-bit group per stage; latency WIDTH/4 cycles.
// Bubbles collapse; stages hold while out_ready is low and in_ready drops only when all are full.
module cla_pipe_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGROUPS = group_count(WIDTH);

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_width_check
    $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [NGROUPS-1:0]              v;
  logic [NGROUPS-1:0]              adv;
  logic [NGROUPS-1:0]              ld;
  logic [NGROUPS-1:0]              c_q;
  logic [NGROUPS-1:0]              grp_cin;
  logic [NGROUPS-1:0]              grp_c3;
  logic [NGROUPS-1:0]              grp_c4;
  logic [NGROUPS-1:0][GROUP_W-1:0] grp_s;
  logic [NGROUPS-1:0][WIDTH-1:0]   op_a;
  logic [NGROUPS-1:0][WIDTH-1:0]   op_b;
  logic [NGROUPS-1:0][WIDTH-1:0]   rem_a_q;
  logic [NGROUPS-1:0][WIDTH-1:0]   rem_b_q;
  logic [NGROUPS-1:0][WIDTH-1:0]   sum_q;
  logic [NGROUPS-1:0][WIDTH-1:0]   sum_in;
  logic                            msb_c3_q;
  logic                            unused_taps;

  // Operands are kept right-aligned: the group a stage resolves is always in bits [3:0].
  assign op_a[0]    = a;
  assign op_b[0]    = sub ? ~b : b;
  assign grp_cin[0] = sub | cin;
  assign sum_in[0]  = '0;
  assign ld[0]      = in_valid && in_ready;

  for (genvar k = 1; k < NGROUPS; k++) begin : g_link
    assign op_a[k]    = rem_a_q[k-1];
    assign op_b[k]    = rem_b_q[k-1];
    assign grp_cin[k] = c_q[k-1];
    assign sum_in[k]  = sum_q[k-1];
    assign ld[k]      = adv[k-1];
  end

  for (genvar k = 0; k < NGROUPS; k++) begin : g_group
    cla_group4 u_grp (
      .a  (op_a[k][GROUP_W-1:0]),
      .b  (op_b[k][GROUP_W-1:0]),
      .c0 (grp_cin[k]),
      .s  (grp_s[k]),
      .c3 (grp_c3[k]),
      .c4 (grp_c4[k])
    );
  end

  always_comb begin
    adv = '0;
    adv[NGROUPS-1] = v[NGROUPS-1] && out_ready;
    for (int k = NGROUPS - 2; k >= 0; k--) begin
      adv[k] = v[k] && (!v[k+1] || adv[k+1]);
    end
  end

  assign in_ready = !v[0] || adv[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      v        <= '0;
      c_q      <= '0;
      sum_q    <= '0;
      rem_a_q  <= '0;
      rem_b_q  <= '0;
      msb_c3_q <= 1'b0;
    end else begin
      for (int k = 0; k < NGROUPS; k++) begin
        if (ld[k]) begin
          v[k]       <= 1'b1;
          c_q[k]     <= grp_c4[k];
          sum_q[k]   <= sum_in[k] | (WIDTH'(grp_s[k]) << (GROUP_W * k));
          rem_a_q[k] <= op_a[k] >> GROUP_W;
          rem_b_q[k] <= op_b[k] >> GROUP_W;
        end else if (adv[k]) begin
          v[k] <= 1'b0;
        end
      end
      if (ld[NGROUPS-1]) begin
        msb_c3_q <= grp_c3[NGROUPS-1];
      end
    end
  end

  // Final-stage remainders and the inner groups' bit-3 carries have no consumer.
  assign unused_taps = ^{rem_a_q[NGROUPS-1], rem_b_q[NGROUPS-1], grp_c3};

  assign out_valid = v[NGROUPS-1];
  assign sum       = sum_q[NGROUPS-1];
  assign cout      = c_q[NGROUPS-1];
  assign ovf       = msb_c3_q ^ c_q[NGROUPS-1];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed checks of cla_pipe_addsub at WIDTH 16, 4 and 32 against hand-computed results.
module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // WIDTH=16 instance
  logic        iv16 = 1'b0, c16 = 1'b0, s16 = 1'b0, or16 = 1'b1;
  logic        ir16, ov16, co16, of16;
  logic [15:0] a16 = '0, b16 = '0, sum16;

  cla_pipe_addsub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(c16), .sub(s16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(co16), .ovf(of16)
  );

  // WIDTH=4 instance
  logic        iv4 = 1'b0, c4 = 1'b0, s4 = 1'b0, or4 = 1'b1;
  logic        ir4, ov4, co4, of4;
  logic [3:0]  a4 = '0, b4 = '0, sum4;

  cla_pipe_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(c4), .sub(s4), .out_valid(ov4), .out_ready(or4), .sum(sum4),
    .cout(co4), .ovf(of4)
  );

  // WIDTH=32 instance
  logic        iv32 = 1'b0, c32 = 1'b0, s32 = 1'b0, or32 = 1'b1;
  logic        ir32, ov32, co32, of32;
  logic [31:0] a32 = '0, b32 = '0, sum32;

  cla_pipe_addsub #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(c32), .sub(s32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .cout(co32), .ovf(of32)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec16_t;

  vec16_t sv [8];

  // One isolated operation: accept, then out_valid low through edge N+2 and high after N+3.
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb, input logic [15:0] es,
                      input logic eco, input logic eof);
    @(negedge clk);
    or16 = 1'b1; iv16 = 1'b1; a16 = a; b16 = b; c16 = ci; s16 = sb;
    #1 chk({tag, "_in_ready"}, ir16, 1);
    @(negedge clk);
    iv16 = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_early"}, ov16, 0);
    @(negedge clk);
    chk({tag, "_valid"}, ov16, 1);
    chk({tag, "_sum"}, sum16, es);
    chk({tag, "_cout"}, co16, eco);
    chk({tag, "_ovf"}, of16, eof);
  endtask

  initial begin
    int tx, rx, cyc;
    logic hold_prev;
    logic [17:0] prev_out;
    logic [3:0] ordy_pat;

    sv[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    sv[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    sv[2] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
    sv[3] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    sv[4] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    sv[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    sv[6] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0};
    sv[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid16", ov16, 0);
    chk("rst_sum16", sum16, 0);
    chk("rst_cout16", co16, 0);
    chk("rst_ovf16", of16, 0);
    chk("rst_ready16", ir16, 1);
    chk("rst_valid4", ov4, 0);
    chk("rst_valid32", ov32, 0);
    chk("rst_sum32", sum32, 0);
    rst = 1'b0;

    // Isolated operations with latency checks
    op16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op16("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    op16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back stream with out_ready toggling 1,0,0,1
    ordy_pat = 4'b1001;
    tx = 0; rx = 0; cyc = 0; hold_prev = 1'b0; prev_out = '0;
    while (rx < 8 && cyc < 80) begin
      @(negedge clk);
      or16 = ordy_pat[cyc % 4];
      if (tx < 8) begin
        iv16 = 1'b1; a16 = sv[tx].a; b16 = sv[tx].b; c16 = sv[tx].cin; s16 = sv[tx].sub;
      end else begin
        iv16 = 1'b0;
      end
      #1;
      if (hold_prev) begin
        chk("stream_hold_valid", ov16, 1);
        chk("stream_hold_data", {co16, of16, sum16}, prev_out);
      end
      chk("stream_in_ready", ir16, !((tx - rx) == 4 && !or16));
      hold_prev = ov16 && !or16;
      prev_out = {co16, of16, sum16};
      if (ov16 && or16) begin
        chk("stream_sum", sum16, sv[rx].s);
        chk("stream_cout", co16, sv[rx].co);
        chk("stream_ovf", of16, sv[rx].ov);
        rx++;
      end
      if (iv16 && ir16) tx++;
      cyc++;
    end
    chk("stream_drain", rx, 8);
    iv16 = 1'b0; or16 = 1'b1;

    // Reset with three operations in flight
    @(negedge clk);
    iv16 = 1'b1; a16 = 16'h0011; b16 = 16'h0022; c16 = 1'b0; s16 = 1'b0;
    @(negedge clk);
    a16 = 16'h0033; b16 = 16'h0044;
    @(negedge clk);
    a16 = 16'h0055; b16 = 16'h0066;
    @(negedge clk);
    iv16 = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("flush_valid", ov16, 0);
    chk("flush_sum", sum16, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_quiet", ov16, 0);
    end
    op16("post_flush", 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // WIDTH=4: single-cycle latency, in_ready stays high under full throughput
    @(negedge clk);
    or4 = 1'b1; iv4 = 1'b1; a4 = 4'h9; b4 = 4'h8; c4 = 1'b1; s4 = 1'b0;
    #1 chk("w4_ready0", ir4, 1);
    @(negedge clk);
    chk("w4_valid0", ov4, 1);
    chk("w4_sum0", sum4, 4'h2);
    chk("w4_cout0", co4, 1);
    chk("w4_ovf0", of4, 1);
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b0; s4 = 1'b0;
    #1 chk("w4_ready1", ir4, 1);
    @(negedge clk);
    chk("w4_valid1", ov4, 1);
    chk("w4_sum1", {co4, of4, sum4}, {2'b00, 4'h7});
    a4 = 4'h2; b4 = 4'h5; c4 = 1'b0; s4 = 1'b1;
    #1 chk("w4_ready2", ir4, 1);
    @(negedge clk);
    chk("w4_valid2", ov4, 1);
    chk("w4_sum2", {co4, of4, sum4}, {2'b00, 4'hD});
    iv4 = 1'b0;
    @(negedge clk);
    chk("w4_idle", ov4, 0);

    // WIDTH=32: eight-stage latency, borrow-free subtract with signed overflow
    @(negedge clk);
    or32 = 1'b1; iv32 = 1'b1; a32 = 32'h8000_0000; b32 = 32'h0000_0001; c32 = 1'b0; s32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (6) @(negedge clk);
    chk("w32_early", ov32, 0);
    @(negedge clk);
    chk("w32_valid", ov32, 1);
    chk("w32_sum", sum32, 32'h7FFF_FFFF);
    chk("w32_cout", co32, 1);
    chk("w32_ovf", of32, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
